j1_uart_responder: RTL and testbench

//  Memory-mapped I/O responder on the J1 core's io_* bus; it is the peripheral side of the CPU's
//  io_rd/io_wr strobes. It provides an 8N1 UART (TX serializer, RX deserializer with RX FIFO), a
//  4-bit LED register and a level interrupt request back to the core. Addresses are one-hot decoded
//  on io_addr, so several selected registers are written together and their read values are ORed.

---
 rtl/j1_io_pkg.sv | 31 +++
 rtl/j1_rx_fifo.sv | 62 ++++++
 rtl/j1_uart_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_j1_uart_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// Shared constants and state types for the J1 I/O responder.
package j1_io_pkg;

    // One-hot address bits on io_addr.
    localparam int unsigned IO_LED_BIT       = 2;
    localparam int unsigned IO_UART_DATA_BIT = 12;
    localparam int unsigned IO_UART_STAT_BIT = 13;

    // STATUS register bit positions.
    localparam int unsigned STAT_TX_READY = 0;
    localparam int unsigned STAT_RX_VALID = 1;
    localparam int unsigned STAT_OVF      = 2;
    localparam int unsigned STAT_FERR     = 3;
    localparam int unsigned STAT_IRQ_EN   = 4;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

endpackage

// File: rtl/j1_rx_fifo.sv
// Synchronous byte FIFO for received UART data with a sticky overflow flag.
module j1_rx_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    input  logic                     ovf_clr_i,
    output logic [7:0]               head_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     ovf_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [7:0]       mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             ovf_q;
    logic             full, empty, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AddrW + 1)'(Depth));
    assign do_pop  = pop_i & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push_i & (~full | do_pop);

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

    // Pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AddrW + 1)'(1);
                2'b01:   count_q <= count_q - (AddrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            // A dropped byte wins over a clear in the same cycle.
            if (push_i & ~do_push) ovf_q <= 1'b1;
            else if (ovf_clr_i)    ovf_q <= 1'b0;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/j1_uart_responder.sv
// J1 io_* bus responder: 8N1 UART with RX FIFO, LED register and level interrupt.
module j1_uart_responder
    import j1_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        interrupt_request,
    output logic [3:0]  leds
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    logic sel_led, sel_data, sel_stat;
    assign sel_led  = io_addr[IO_LED_BIT];
    assign sel_data = io_addr[IO_UART_DATA_BIT];
    assign sel_stat = io_addr[IO_UART_STAT_BIT];

    logic unused_bits;
    assign unused_bits = ^{io_dout[15:8], io_addr[15:14], io_addr[11:3], io_addr[1:0]};

    logic [15:0] io_din_q, rd_data;
    logic [3:0]  leds_q;
    logic        irq_en_q, ferr_q, irq_q;

    logic        fifo_push, fifo_pop, fifo_empty, fifo_ovf;
    logic [7:0]  fifo_head;
    logic [$clog2(RX_DEPTH):0] fifo_count;
    logic        rx_valid;

    assign rx_valid = (fifo_count != '0);

    // ---------------- TX ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;
    logic            tx_ready, tx_start;

    assign tx_ready = (tx_state_q == TxIdle);
    assign tx_start = io_wr & sel_data & tx_ready;

    // TX next state: one bit period per state, data shifted out LSB first.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (tx_start) begin
                    tx_state_d = TxStart;
                    tx_shift_d = io_dout[7:0];
                    txd_d      = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- RX ----------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic            rx_fall, ferr_set;

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX next state: half-bit start check, then sample at full-bit spacing.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        fifo_push  = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        fifo_push  = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        ferr_set   = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end
            end
            RxWaitHigh: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign fifo_pop = io_rd & sel_data;

    j1_rx_fifo #(
        .Depth (RX_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (rx_shift_q),
        .pop_i       (fifo_pop),
        .ovf_clr_i   (io_wr & sel_stat & io_dout[STAT_OVF]),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ovf_o       (fifo_ovf)
    );

    // ---------------- Bus side ----------------
    // Read mux: selected sources are ORed; all values are pre-write state.
    always_comb begin
        rd_data = '0;
        if (sel_led)  rd_data = rd_data | {12'b0, leds_q};
        if (sel_data) rd_data = rd_data | {8'b0, (fifo_empty ? 8'h00 : fifo_head)};
        if (sel_stat) rd_data = rd_data | {11'b0, irq_en_q, ferr_q, fifo_ovf, rx_valid, tx_ready};
    end

    // Bus registers: read data, LEDs, irq enable, framing-error flag, interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_din_q <= '0;
            leds_q   <= '0;
            irq_en_q <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (io_rd)           io_din_q <= rd_data;
            if (io_wr & sel_led) leds_q   <= io_dout[3:0];
            if (io_wr & sel_stat) irq_en_q <= io_dout[STAT_IRQ_EN];
            if (ferr_set)        ferr_q   <= 1'b1;
            else if (io_wr & sel_stat & io_dout[STAT_FERR]) ferr_q <= 1'b0;
            irq_q <= irq_en_q & rx_valid;
        end
    end

    assign io_din            = io_din_q;
    assign uart_txd          = txd_q;
    assign interrupt_request = irq_q;
    assign leds              = leds_q;

endmodule

// File: tb/tb_j1_uart_responder.sv
// Directed self-checking bench for j1_uart_responder (16 clocks per UART bit).
module tb_j1_uart_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd, io_wr;
    logic [15:0] io_addr, io_dout, io_din;
    logic        uart_rxd, uart_txd, interrupt_request;
    logic [3:0]  leds;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    j1_uart_responder #(
        .CLKS_PER_BIT (16),
        .RX_DEPTH     (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_dout           (io_dout),
        .io_din            (io_din),
        .uart_rxd          (uart_rxd),
        .uart_txd          (uart_txd),
        .interrupt_request (interrupt_request),
        .leds              (leds)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        io_addr = a;
        io_dout = d;
        io_wr   = 1'b1;
        tick(1);
        io_wr   = 1'b0;
        io_addr = '0;
        io_dout = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        io_addr = a;
        io_rd   = 1'b1;
        tick(1);
        io_rd   = 1'b0;
        io_addr = '0;
        d       = io_din;
    endtask

    // Drive one 8N1 frame; a good stop bit is followed by one idle bit time.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            tick(16);
        end
        if (stop) tick(16);
    endtask

    initial begin
        logic [15:0] rd;
        logic [9:0]  frame;

        reset    = 1'b1;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = '0;
        io_dout  = '0;
        uart_rxd = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_io_din", io_din, 16'h0000);
        check("rst_txd", {15'b0, uart_txd}, 16'h0001);
        check("rst_irq", {15'b0, interrupt_request}, 16'h0000);
        check("rst_leds", {12'b0, leds}, 16'h0000);
        bus_read(16'h2000, rd);
        check("rst_status", rd, 16'h0001);

        // LED register and empty select
        bus_write(16'h0004, 16'h0005);
        check("led_out", {12'b0, leds}, 16'h0005);
        bus_read(16'h0004, rd);
        check("led_rd", rd, 16'h0005);
        bus_read(16'h0000, rd);
        check("nosel_rd", rd, 16'h0000);

        // 1. TX of 0x41
        bus_write(16'h1000, 16'h0041);
        check("tx_start_edge", {15'b0, uart_txd}, 16'h0000);
        bus_read(16'h2000, rd);
        check("tx_busy_status", rd, 16'h0000);
        bus_write(16'h1000, 16'h00FF);   // ignored while busy
        tick(6);
        frame = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), {15'b0, uart_txd}, {15'b0, frame[k]});
            tick(16);
        end
        // Now 8 clocks past the end of the stop bit window start + 8 => at 168; line idle.
        check("tx_idle_txd", {15'b0, uart_txd}, 16'h0001);
        bus_read(16'h2000, rd);
        check("tx_ready_after", rd, 16'h0001);

        // 2. RX of 0xA5
        send_byte(8'hA5, 1'b1);
        bus_read(16'h2000, rd);
        check("rx_status", rd, 16'h0003);
        bus_read(16'h1000, rd);
        check("rx_data", rd, 16'h00A5);
        bus_read(16'h1000, rd);
        check("rx_empty_rd", rd, 16'h0000);

        // 3. Overflow with nine bytes
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b1);
        bus_read(16'h2000, rd);
        check("ovf_status", rd, 16'h0007);
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h1000, rd);
            check($sformatf("ovf_data%0d", i), rd, 16'h0010 + 16'(i));
        end
        bus_read(16'h1000, rd);
        check("ovf_9th_lost", rd, 16'h0000);
        bus_write(16'h2000, 16'h0004);
        bus_read(16'h2000, rd);
        check("ovf_cleared", rd, 16'h0001);

        // 4. Framing error, long break, then a good byte
        send_byte(8'h81, 1'b0);
        tick(100);
        bus_read(16'h2000, rd);
        check("ferr_status", rd, 16'h0009);
        uart_rxd = 1'b1;
        tick(20);
        send_byte(8'h3C, 1'b1);
        bus_read(16'h2000, rd);
        check("ferr_then_rx", rd, 16'h000B);
        bus_read(16'h1000, rd);
        check("ferr_rx_data", rd, 16'h003C);
        bus_read(16'h1000, rd);
        check("ferr_one_byte", rd, 16'h0000);
        bus_write(16'h2000, 16'h0008);
        bus_read(16'h2000, rd);
        check("ferr_cleared", rd, 16'h0001);

        // 5. Interrupt
        bus_write(16'h2000, 16'h0010);
        tick(2);
        check("irq_idle", {15'b0, interrupt_request}, 16'h0000);
        send_byte(8'h55, 1'b1);
        check("irq_high", {15'b0, interrupt_request}, 16'h0001);
        bus_read(16'h2000, rd);
        check("irq_status", rd, 16'h0013);
        bus_read(16'h1000, rd);
        check("irq_data", rd, 16'h0055);
        tick(2);
        check("irq_low", {15'b0, interrupt_request}, 16'h0000);

        // 6. LED+DATA together, then reset mid-frame
        bus_write(16'h1004, 16'h000F);
        check("multi_leds", {12'b0, leds}, 16'h000F);
        check("multi_tx_start", {15'b0, uart_txd}, 16'h0000);
        bus_read(16'h2004, rd);
        check("multi_or_rd", rd, 16'h001F);
        tick(87);
        check("multi_tx_bit4", {15'b0, uart_txd}, 16'h0000);
        reset = 1'b1;
        tick(1);
        check("mid_rst_txd", {15'b0, uart_txd}, 16'h0001);
        check("mid_rst_leds", {12'b0, leds}, 16'h0000);
        check("mid_rst_irq", {15'b0, interrupt_request}, 16'h0000);
        reset = 1'b0;
        bus_read(16'h2000, rd);
        check("post_rst_status", rd, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
